// File: rtl/pipe_ctrl.sv
// Hazard and forwarding control for a 5-stage in-order pipeline.
// Tracks the producers ahead of ID and decides stall, bubble, flush and operand forwarding.
module pipe_ctrl #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_rd_we,
    input  logic        id_is_load,
    input  logic        ex_redirect,
    output logic        stall_if,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cycles
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       load;
    } stage_t;

    // The regfile is write-through, so a WB-stage producer never needs action and
    // its record would never be read; only EX and MEM are kept.
    stage_t ex_q;
    stage_t mem_q;
    stage_t ex_d;

    logic m_ex1, m_ex2, m_mem1, m_mem2;
    logic hazard;
    logic [1:0] fwd_a_d, fwd_b_d;

    function automatic logic match(input stage_t s, input logic [4:0] src, input logic used);
        return used && (src != 5'd0) && s.valid && s.we && (s.rd == src);
    endfunction

    // Youngest producer wins: EX beats MEM.
    function automatic logic [1:0] fwd_sel(input logic mex, input logic mmem);
        if (mex)
            return 2'b01;
        else if (mmem)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        m_ex1  = match(ex_q, id_rs1_addr, id_rs1_used);
        m_ex2  = match(ex_q, id_rs2_addr, id_rs2_used);
        m_mem1 = match(mem_q, id_rs1_addr, id_rs1_used);
        m_mem2 = match(mem_q, id_rs2_addr, id_rs2_used);

        if (FWD_EN)
            hazard = id_valid && ex_q.load && (m_ex1 || m_ex2);
        else
            hazard = id_valid && (m_ex1 || m_ex2 || m_mem1 || m_mem2);

        // A taken redirect kills the ID instruction, so any hazard it had is moot.
        flush_id  = rst_n && ex_redirect;
        stall_if  = rst_n && hazard && !ex_redirect;
        stall_id  = stall_if;
        bubble_ex = stall_if || flush_id;

        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (FWD_EN && id_valid && !bubble_ex) begin
            fwd_a_d = fwd_sel(m_ex1, m_mem1);
            fwd_b_d = fwd_sel(m_ex2, m_mem2);
        end

        ex_d = '0;
        if (id_valid && !bubble_ex) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = id_rd_addr;
            ex_d.we    = id_rd_we;
            ex_d.load  = id_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            mem_q        <= '0;
            fwd_a        <= 2'b00;
            fwd_b        <= 2'b00;
            stall_cycles <= 16'd0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            fwd_a <= fwd_a_d;
            fwd_b <= fwd_b_d;
            if (stall_id && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter FWD_EN, default 1: 1 = EX/MEM/WB forwarding enabled; 0 = no forwarding, resolve all RAW hazards by stalling.
REQ-002 Port clk  input  1  sole clock; all state updates on posedge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port id_valid  input  1  ID stage holds a real instruction.
REQ-005 Ports id_rs1_addr, id_rs2_addr  input  5 each  ID source register addresses.
REQ-006 Ports id_rs1_used, id_rs2_used  input  1 each  the ID instruction reads that source.
REQ-007 Port id_rd_addr  input  5  ID destination register.
REQ-008 Port id_rd_we  input  1  the ID instruction writes rd.
REQ-009 Port id_is_load  input  1  the ID instruction is a load; data is available only at end of MEM.
REQ-010 Port ex_redirect  input  1  branch/jump resolved taken in EX this cycle.
REQ-011 Port stall_if  output  1  hold PC and the IF/ID register.
REQ-012 Port stall_id  output  1  hold the ID stage.
REQ-013 Port bubble_ex  output  1  load a NOP into ID/EX at the next edge.
REQ-014 Port flush_id  output  1  invalidate IF/ID at the next edge.
REQ-015 Ports fwd_a, fwd_b  output  2 each  EX operand select, registered: 00 regfile, 01 MEM-stage result, 10 WB-stage result, 11 never driven.
REQ-016 Port stall_cycles  output  16  performance counter of stall cycles.

Function
REQ-017 The block SHALL keep shadow records {valid, rd, we, load} for the EX, MEM and WB stages.
REQ-018 At each edge: EX <= ID info if id_valid and not bubble_ex, else invalid; MEM <= EX; WB <= MEM.
REQ-019 match(S, src) SHALL be true iff src_used, src != 0, S.valid, S.we and S.rd == src.
REQ-020 Regfile is write-through: a WB-stage match needs no action.
REQ-021 FWD_EN=1: hazard = id_valid and match(EX, rs1 or rs2) with EX.load = 1.
REQ-022 FWD_EN=0: hazard = id_valid and match(EX or MEM, rs1 or rs2), regardless of load.
REQ-023 On hazard (no redirect): stall_if = stall_id = bubble_ex = 1 and flush_id = 0, combinationally in the same cycle.
REQ-024 On ex_redirect = 1: flush_id = bubble_ex = 1 and stall_if = stall_id = 0, overriding any hazard in that cycle.
REQ-025 Otherwise stall_if, stall_id, bubble_ex and flush_id SHALL all be 0.
REQ-026 fwd_x SHALL register on each edge:
  - 01 if match(EX, src), non-load;
  - else 10 if match(MEM, src);
  - else 00.
REQ-027 fwd_x SHALL be 00 when bubble_ex = 1, when id_valid = 0, or when FWD_EN = 0.
REQ-028 The EX match SHALL take priority over the MEM match (youngest producer wins).
REQ-029 A load-use pair SHALL incur exactly one stall cycle with FWD_EN=1; the following cycle the consumer enters EX with fwd_x = 10.
REQ-030 stall_cycles SHALL increment by 1 on each edge where stall_id = 1, and saturate at 0xFFFF.
REQ-031 Register x0 SHALL never cause a stall or forward.

Reset
REQ-032 While rst_n = 0, all shadow valids, fwd_a, fwd_b and stall_cycles SHALL be 0, and all combinational outputs SHALL be forced to 0.
REQ-033 Reset assertion mid-stall SHALL clear the stall immediately, asynchronously.
REQ-034 The first edge after rst_n rises SHALL behave as an empty pipeline.

Verification
REQ-035 Back-to-back pair "add x5" then "sub uses x5" as rs1, FWD_EN=1: no stall; fwd_a = 01 in the sub's EX cycle.
REQ-036 "lw x6" then an instruction using x6 as rs2: one cycle with stall_if/stall_id/bubble_ex = 1, then fwd_b = 10; stall_cycles = 1.
REQ-037 Producer of x7, one unrelated instruction, then consumer of x7: fwd = 10, no stall; with a gap of 2 instructions: fwd = 00.
REQ-038 Load-use hazard and ex_redirect in the same cycle: flush_id = 1, bubble_ex = 1, stall_if = 0; stall_cycles unchanged.
REQ-039 FWD_EN=0, "add x5" then a consumer of x5: two stall cycles, fwd always 00, stall_cycles = 2.
REQ-040 Writes to x0 followed by readers of x0: no stalls, fwd = 00; rst_n pulsed low during a stall: outputs 0 immediately, counter reads 0.
